// File: rtl/inv_pipe_pkg.sv
// Shared constants for the inv_pipe block: output transfer counter width and saturation value.
package inv_pipe_pkg;
  localparam int                  COUNT_W   = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;
endpackage

// File: rtl/inv_pipe_stage.sv
// One valid/ready register slice of the inv_pipe chain; accepts a new word whenever empty or draining.
module inv_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  logic         vld_p0;
  logic [W-1:0] dat_p0;

  assign up_ready = !vld_p0 || dn_ready;
  assign dn_valid = vld_p0;
  assign dn_data  = dat_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      dat_p0 <= '0;
    end else if (up_ready) begin
      vld_p0 <= up_valid;
      if (up_valid) dat_p0 <= up_data;
    end
  end
endmodule

// File: rtl/inv_pipe.sv
// Elastic DEPTH-stage pipeline that XORs each word with INV_MASK unless bypassed, counting output transfers.
// Optional INV_PIPE_PARITY_EN adds an out_parity bit carried alongside the data.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
`ifdef INV_PIPE_PARITY_EN
  output logic               out_parity,
`endif
  output logic [COUNT_W-1:0] out_count
);
`ifdef INV_PIPE_PARITY_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 16'd1;
  endfunction

  logic [DEPTH:0]   vld;
  logic [DEPTH:0]   rdy;
  logic [PW-1:0]    dat [DEPTH+1];
  logic [WIDTH-1:0] xform_p0;
  logic [COUNT_W-1:0] out_count_q;

  // Stage 0 input: the only point where the word is transformed
  assign xform_p0 = in_bypass ? in_data : (in_data ^ INV_MASK);
`ifdef INV_PIPE_PARITY_EN
  assign dat[0]     = {^xform_p0, xform_p0};
  assign out_parity = dat[DEPTH][WIDTH];
`else
  assign dat[0]     = xform_p0;
`endif

  assign vld[0]     = in_valid;
  assign in_ready   = rdy[0];
  assign rdy[DEPTH] = out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      inv_pipe_stage #(.W(PW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (vld[i]),
        .up_ready (rdy[i]),
        .up_data  (dat[i]),
        .dn_valid (vld[i+1]),
        .dn_ready (rdy[i+1]),
        .dn_data  (dat[i+1])
      );
    end
  endgenerate

  // Output boundary
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH][WIDTH-1:0];
  assign out_count = out_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_q <= '0;
    end else if (out_valid && out_ready) begin
      out_count_q <= sat_inc(out_count_q);
    end
  end
endmodule

// File: tb/tb_inv_pipe.sv
// Directed bench for inv_pipe (WIDTH=8, DEPTH=2, default mask); parity checks enabled with INV_PIPE_PARITY_EN.
module tb_inv_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_bypass;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_count;
`ifdef INV_PIPE_PARITY_EN
  logic        out_parity;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  inv_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef INV_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic byp);
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = byp;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_bypass = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // single inverted word, two-cycle latency
    push(8'h5A, 1'b0);
    step();
    in_valid = 1'b0;
    check("lat1_out_valid", 32'(out_valid), 32'd0);
    step();
    check("lat2_out_valid", 32'(out_valid), 32'd1);
    check("inv_5a",         32'(out_data),  32'hA5);
    step();
    check("cnt_after_1",    32'(out_count), 32'd1);
    check("drain_valid",    32'(out_valid), 32'd0);

    // bypassed word
    push(8'h5A, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("byp_5a", 32'(out_data), 32'h5A);
    step();

    // back-to-back stream
    push(8'h00, 1'b0);
    step();
    push(8'hFF, 1'b0);
    step();
    check("b2b_0_valid", 32'(out_valid), 32'd1);
    check("b2b_0",       32'(out_data),  32'hFF);
    push(8'h0F, 1'b0);
    step();
    in_valid = 1'b0;
    check("b2b_1",       32'(out_data),  32'h00);
    step();
    check("b2b_2",       32'(out_data),  32'hF0);
    step();
    check("b2b_count",   32'(out_count), 32'd5);

    // backpressure: stall with full pipe, then drain in order
    out_ready = 1'b0;
    push(8'h11, 1'b1);
    step();
    check("bp_ready_half", 32'(in_ready), 32'd1);
    push(8'h22, 1'b1);
    step();
    push(8'h33, 1'b1);
    check("bp_ready_full", 32'(in_ready),  32'd0);
    check("bp_valid",      32'(out_valid), 32'd1);
    check("bp_head",       32'(out_data),  32'h11);
    step();
    check("bp_hold_data",  32'(out_data),  32'h11);
    check("bp_hold_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_pass_ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    check("bp_word2",      32'(out_data),  32'h22);
    step();
    check("bp_word3",      32'(out_data),  32'h33);
    check("bp_word3_vld",  32'(out_valid), 32'd1);
    step();
    check("bp_empty",      32'(out_valid), 32'd0);
    check("bp_count",      32'(out_count), 32'd8);

    // reset asserted mid-cycle with a full pipe
    out_ready = 1'b0;
    push(8'h44, 1'b1);
    step();
    push(8'h55, 1'b1);
    step();
    in_valid = 1'b0;
    check("mr_full_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid",  32'(out_valid), 32'd0);
    check("mr_out_data",   32'(out_data),  32'h00);
    check("mr_out_count",  32'(out_count), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("mr_in_ready",   32'(in_ready),  32'd1);
    push(8'h66, 1'b0);
    step();
    in_valid = 1'b0;
    check("mr_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("mr_lat2_valid", 32'(out_valid), 32'd1);
    check("mr_data",       32'(out_data),  32'h99);
    step();
    check("mr_count",      32'(out_count), 32'd1);

    // counter saturation
    force dut.out_count_q = 16'hFFFE;
    #1;
    release dut.out_count_q;
    check("sat_preset", 32'(out_count), 32'hFFFE);
    push(8'h01, 1'b0);
    step();
    push(8'h02, 1'b0);
    step();
    push(8'h03, 1'b0);
    step();
    in_valid = 1'b0;
    check("sat_1", 32'(out_count), 32'hFFFF);
    step();
    check("sat_2", 32'(out_count), 32'hFFFF);
    step();
    check("sat_3", 32'(out_count), 32'hFFFF);
    check("sat_empty", 32'(out_valid), 32'd0);

`ifdef INV_PIPE_PARITY_EN
    push(8'h01, 1'b1);
    step();
    push(8'h03, 1'b1);
    step();
    in_valid = 1'b0;
    check("par_01_data", 32'(out_data),   32'h01);
    check("par_01",      32'(out_parity), 32'd1);
    step();
    check("par_03_data", 32'(out_data),   32'h03);
    check("par_03",      32'(out_parity), 32'd0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
